// File: rtl/cordic_vector.sv
// Iterative 12-stage vectoring CORDIC: computes atan2(y, x) over -PI..PI and the
// gain-scaled magnitude of a Q3.16 vector, one micro-rotation per enabled clock.
module cordic_vector #(
  parameter int STAGES = 12,
  parameter int W      = 19
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_en,
  input  logic                start,
  input  logic signed [W-1:0] x_in,
  input  logic signed [W-1:0] y_in,
  output logic signed [W-1:0] angle_o,
  output logic signed [W-1:0] mag_o,
  output logic                done,
  output logic                busy
);

  localparam logic signed [W-1:0] ONE     = 19'sh10000;
  localparam logic signed [W-1:0] NEG_ONE = -19'sh10000;
  localparam logic signed [W-1:0] PI      = 19'sh3243F;
  localparam logic signed [W-1:0] NEG_PI  = -19'sh3243F;
  localparam logic [3:0]          LAST    = 4'(STAGES - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  state_t              r_state, w_state_nxt;
  logic signed [W-1:0] r_x, r_y, r_z;
  logic signed [W-1:0] r_angle, r_mag;
  logic [3:0]          r_cnt;
  logic                r_zero, r_done;

  logic signed [W-1:0] w_xs, w_ys, w_x0, w_y0, w_z0;
  logic signed [W-1:0] w_xsh, w_ysh, w_xn, w_yn, w_zn, w_zsat, w_atan;
  logic                w_load, w_iter, w_last, w_fin;

  function automatic logic signed [W-1:0] sat_unit(input logic signed [W-1:0] v);
    if (v > ONE)          return ONE;
    else if (v < NEG_ONE) return NEG_ONE;
    else                  return v;
  endfunction

  function automatic logic signed [W-1:0] atan_lut(input logic [3:0] i);
    case (i)
      4'd0:    return 19'sh0C910;
      4'd1:    return 19'sh076B2;
      4'd2:    return 19'sh03EB7;
      4'd3:    return 19'sh01FD6;
      4'd4:    return 19'sh00FFB;
      4'd5:    return 19'sh007FF;
      4'd6:    return 19'sh00400;
      4'd7:    return 19'sh00200;
      4'd8:    return 19'sh00100;
      4'd9:    return 19'sh00080;
      4'd10:   return 19'sh00040;
      4'd11:   return 19'sh00020;
      default: return 19'sh00000;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst)         r_state <= S_IDLE;
    else if (clk_en) r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_BUSY;
      S_BUSY:  if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs / datapath controls
  always_comb begin
    busy   = (r_state != S_IDLE);
    w_load = (r_state == S_IDLE) && start;
    w_iter = (r_state == S_BUSY);
    w_last = (r_cnt == LAST);
    w_fin  = w_iter && w_last;
  end

  // Left half-plane inputs are folded into the right half-plane by a +/-PI pre-rotation
  always_comb begin
    w_xs = sat_unit(x_in);
    w_ys = sat_unit(y_in);
    w_x0 = w_xs;
    w_y0 = w_ys;
    w_z0 = '0;
    if (w_xs[W-1]) begin
      w_x0 = -w_xs;
      w_y0 = -w_ys;
      w_z0 = w_ys[W-1] ? NEG_PI : PI;
    end
  end

  always_comb begin
    w_atan = atan_lut(r_cnt);
    w_xsh  = r_x >>> r_cnt;
    w_ysh  = r_y >>> r_cnt;
    if (!r_y[W-1]) begin
      w_xn = r_x + w_ysh;
      w_yn = r_y - w_xsh;
      w_zn = r_z + w_atan;
    end else begin
      w_xn = r_x - w_ysh;
      w_yn = r_y + w_xsh;
      w_zn = r_z - w_atan;
    end
    if (w_zn > PI)          w_zsat = PI;
    else if (w_zn < NEG_PI) w_zsat = NEG_PI;
    else                    w_zsat = w_zn;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_cnt   <= '0;
      r_zero  <= 1'b0;
      r_done  <= 1'b0;
      r_angle <= '0;
      r_mag   <= '0;
    end else if (clk_en) begin
      if (w_load) begin
        r_x    <= w_x0;
        r_y    <= w_y0;
        r_z    <= w_z0;
        r_cnt  <= '0;
        r_zero <= (w_xs == '0) && (w_ys == '0);
      end else if (w_iter) begin
        r_x   <= w_xn;
        r_y   <= w_yn;
        r_z   <= w_zn;
        r_cnt <= w_last ? 4'd0 : r_cnt + 4'd1;
      end
      r_done <= w_fin;
      // The final micro-rotation result is published on the same edge it is computed
      if (w_fin) begin
        r_angle <= r_zero ? '0 : w_zsat;
        r_mag   <= r_zero ? '0 : w_xn;
      end
    end
  end

  assign angle_o = r_angle;
  assign mag_o   = r_mag;
  assign done    = r_done;

endmodule

// File: tb/tb_cordic_vector.sv
// Scoreboard bench for cordic_vector: real-valued atan2/hypot reference, handshake,
// stall and reset-abort checks.
module tb_cordic_vector;

  logic        clk = 1'b0;
  logic        rst, clk_en, start;
  logic [18:0] x_in, y_in;
  logic [18:0] angle_o, mag_o;
  logic        done, busy;

  cordic_vector dut (
    .clk     (clk),
    .rst     (rst),
    .clk_en  (clk_en),
    .start   (start),
    .x_in    (x_in),
    .y_in    (y_in),
    .angle_o (angle_o),
    .mag_o   (mag_o),
    .done    (done),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  localparam int PI_Q   = 32'h3243F;
  localparam int TWO_PI = 2 * PI_Q;
  localparam int TOL    = 32'h40;

  typedef struct {
    string tag;
    int    ang;
    int    mag;
    int    tol;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_err  = 0;
  int   n_done = 0;
  logic done_q = 1'b0;

  task automatic chk(input string tag, input int got, input int exp, input int tol);
    n_chk++;
    if (got - exp > tol || exp - got > tol) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) tol %0d",
               tag, got, got, exp, exp, tol);
    end
  endtask

  function automatic int s19(input logic [18:0] v);
    return int'($signed(v));
  endfunction

  function automatic int sat_q(input int v);
    if (v > 65536)  return 65536;
    if (v < -65536) return -65536;
    return v;
  endfunction

  task automatic push(input string tag, input logic [18:0] x, input logic [18:0] y);
    exp_t e;
    int   xs, ys;
    real  xr, yr;
    xs = sat_q(s19(x));
    ys = sat_q(s19(y));
    xr = xs / 65536.0;
    yr = ys / 65536.0;
    e.tag = tag;
    if (xs == 0 && ys == 0) begin
      e.ang = 0;
      e.mag = 0;
      e.tol = 0;
    end else begin
      e.ang = int'($atan2(yr, xr) * 65536.0);
      e.mag = int'(1.646760258 * $sqrt(xr * xr + yr * yr) * 65536.0);
      e.tol = TOL;
    end
    sb.push_back(e);
  endtask

  // Result monitor: compares each completion against the oldest expectation
  always @(negedge clk) begin : mon
    exp_t e;
    int   a;
    if (done && !done_q) begin
      n_done++;
      if (sb.size() == 0) chk("unexpected_done", sb.size(), 1, 0);
      else begin
        e = sb.pop_front();
        a = s19(angle_o);
        if (a - e.ang > PI_Q)      a = a - TWO_PI;
        else if (e.ang - a > PI_Q) a = a + TWO_PI;
        chk({e.tag, "_ang"}, a, e.ang, e.tol);
        chk({e.tag, "_mag"}, s19(mag_o), e.mag, e.tol);
        chk({e.tag, "_range"}, int'(s19(angle_o) <= PI_Q && s19(angle_o) >= -PI_Q), 1, 0);
      end
    end
    done_q <= done;
  end

  // One transaction: start sampled at the next edge; optional clk_en stall and a
  // stray start/input change while busy. Returns enabled+disabled edges to done.
  task automatic go(input string tag, input logic [18:0] x, input logic [18:0] y,
                    input int stall_at, input int stall_len, input bit poke,
                    output int lat);
    x_in  = x;
    y_in  = y;
    push(tag, x, y);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 0;
    for (int k = 1; k <= 60; k++) begin
      if (poke && k == 3) begin
        start = 1'b1;
        x_in  = 19'h10000;
        y_in  = 19'h10000;
      end
      if (k == stall_at) clk_en = 1'b0;
      if (k == stall_at + stall_len) clk_en = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
    end
    clk_en = 1'b1;
    if (lat == 0) chk({tag, "_timeout"}, 0, 1, 0);
    @(posedge clk); #1;
    chk({tag, "_done_clr"}, int'(done), 0, 0);
    chk({tag, "_idle"}, int'(busy), 0, 0);
  endtask

  initial begin
    int          lat, d0;
    int          rx, ry;
    logic [18:0] vx[8], vy[8];
    vx = '{19'h10000, 19'h00000, 19'h70000, 19'h70000, 19'h00000, 19'h30000, 19'h00000, 19'h08000};
    vy = '{19'h00000, 19'h10000, 19'h70000, 19'h00000, 19'h00000, 19'h00000, 19'h48000, 19'h78000};

    rst = 1'b1; clk_en = 1'b1; start = 1'b0; x_in = '0; y_in = '0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    x_in  = 19'h10000;
    @(posedge clk); #1;
    start = 1'b0;
    chk("rst_angle", s19(angle_o), 0, 0);
    chk("rst_mag", s19(mag_o), 0, 0);
    chk("rst_done", int'(done), 0, 0);
    chk("rst_busy", int'(busy), 0, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_start_ignored", int'(busy), 0, 0);

    for (int i = 0; i < 8; i++) begin
      go($sformatf("vec%0d", i), vx[i], vy[i], 0, 0, 1'b0, lat);
      chk($sformatf("vec%0d_lat", i), lat, 12, 0);
    end

    go("stall", 19'h0C000, 19'h05000, 4, 5, 1'b0, lat);
    chk("stall_lat", lat, 17, 0);

    go("poke", 19'h0A000, 19'h7A000, 0, 0, 1'b1, lat);
    chk("poke_lat", lat, 12, 0);
    @(posedge clk); #1;
    chk("poke_no_rerun", int'(busy), 0, 0);

    // Abort mid-BUSY with a coincident start
    x_in  = 19'h04000;
    y_in  = 19'h0C000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    rst   = 1'b0;
    start = 1'b0;
    chk("abort_busy", int'(busy), 0, 0);
    chk("abort_angle", s19(angle_o), 0, 0);
    chk("abort_mag", s19(mag_o), 0, 0);
    chk("abort_done", int'(done), 0, 0);
    d0 = n_done;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_done", n_done, d0, 0);
    chk("abort_idle", int'(busy), 0, 0);
    go("post_abort", 19'h04000, 19'h0C000, 0, 0, 1'b0, lat);
    chk("post_abort_lat", lat, 12, 0);

    for (int i = 0; i < 1000; i++) begin
      // Very short vectors are excluded: their angle is dominated by truncation noise
      do begin
        rx = int'($urandom_range(131072)) - 65536;
        ry = int'($urandom_range(131072)) - 65536;
      end while (longint'(rx) * rx + longint'(ry) * ry < 64'd1073741824);
      go("rand", 19'(rx), 19'(ry), 0, 0, 1'b0, lat);
      if (lat != 12) chk("rand_lat", lat, 12, 0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cordic_vector.md
# cordic_vector

Iterative 12-stage CORDIC engine in vectoring mode: takes a Cartesian vector (x, y) and returns its angle atan2(y, x) over the full range -PI..PI, plus its gain-scaled magnitude. It performs the inverse of the rotation-mode cosine/sine engine and uses the same Q3.16 signed fixed-point format, the same start/done handshake and the same clock-enable convention. It shares the existing atan lookup (stage index 0..11) with that engine.

## Interface
- STAGES, 12: number of CORDIC iterations. Fixed; the atan table covers stages 0..11.
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- clk_en  in  1  global clock enable; when low, all state and outputs hold
- start  in  1  request; sampled only in IDLE while clk_en is high
- x_in  in  19  signed Q3.16 x component
- y_in  in  19  signed Q3.16 y component
- angle_o  out  19  signed Q3.16 angle in radians, registered
- mag_o  out  19  signed Q3.16 magnitude × 1.64676 (CORDIC gain, not removed), registered
- done  out  1  one-cycle pulse when angle_o and mag_o update
- busy  out  1  high whenever state ≠ IDLE

## Operation
- Constants:
  - PI = 0x3243F
  - atan(2^-i), i = 0..11: 0x0C910, 0x076B2, 0x03EB7, 0x01FD6, 0x00FFB, 0x007FF, 0x00400, 0x00200, 0x00100, 0x00080, 0x00040, 0x00020
- States: IDLE, BUSY, DONE. An unused encoding returns to IDLE.
- IDLE + start:
  - Capture inputs, saturating each to [-0x10000, +0x10000].
  - Set zero_flag when both saturated inputs equal 0.
  - Pre-rotation:
    - If x ≥ 0: (x, y, z) = (x, y, 0).
    - If x < 0 and y ≥ 0: (-x, -y, +PI).
    - If x < 0 and y < 0: (-x, -y, -PI).
  - Set count = 0 and go to BUSY.
- BUSY, iteration i = count. Shifts are arithmetic and use the old x and y values:
  - If y ≥ 0: x += y>>>i; y -= x>>>i; z += atan_i.
  - Otherwise: x -= y>>>i; y += x>>>i; z -= atan_i.
- Leaving BUSY: when count = 11, go to DONE and assert done.
  - angle_o = z_final saturated to [-PI, +PI].
  - mag_o = x_final.
  - If zero_flag is set, both outputs are 0.
- DONE: clear done, go to IDLE.
- Arithmetic:
  - Internal x, y, z are 19-bit. The input limit guarantees no overflow: |x| ≤ 2.33 and |z| ≤ PI + 1.75 < 4.
  - No rounding; shifts truncate toward -inf.
- Accuracy: angle within ±0x40 LSB of ideal; mag_o within ±0x40 LSB of 1.64676·√(x²+y²).
- start outside IDLE is ignored, with no queuing.
- Input changes after capture have no effect.

## Timing
- Reset values: state = IDLE, done = 0, busy = 0, angle_o = 0, mag_o = 0, count = 0.
- Latency: start is sampled at enabled edge N.
  - Iterations run on enabled edges N+1..N+12.
  - done = 1 and outputs are valid after edge N+12.
  - done clears at N+13, and IDLE is re-entered the same edge.
  - The earliest next start is accepted at edge N+14.
- All timing counts enabled edges only. A clk_en low for k cycles anywhere stretches latency by k; done stays high through a stall in DONE.
- angle_o and mag_o hold their last result until the next completion.
- rst mid-operation aborts immediately:
  - Outputs return to 0 and no done pulse is generated.
  - A start coincident with rst is ignored.

## Test plan
- Axis vectors. Expected: angle ±0x40, mag ±0x40.
  - x = 0x10000, y = 0 -> angle_o ≈ 0x00000, mag_o ≈ 0x1A593.
  - x = 0, y = 0x10000 -> angle_o ≈ 0x1921F, mag_o ≈ 0x1A593.
- Third quadrant: x = y = 0x70000 (-1.0) -> angle_o ≈ 0x5A4D1 (-3PI/4), mag_o ≈ 0x25432.
- Branch cut and zero: x = 0x70000, y = 0 -> |angle_o| ≥ PI - 0x40 and never beyond ±0x3243F. x = y = 0 -> angle_o = 0, mag_o = 0, done after 12 busy cycles.
- Saturation: x = 0x30000, y = 0 -> same result as x = 0x10000.
- Handshake and stall:
  - done is exactly one cycle, 12 enabled cycles after start.
  - A second start while busy is ignored.
  - Holding clk_en low for 5 cycles mid-BUSY delays done by exactly 5.
- Reset mid-BUSY: busy → 0, outputs → 0, no done. A fresh start afterwards completes normally.
- Random sweep of 1000 vectors within ±1.0 against a reference atan2/hypot model within the stated tolerances.
